// File: rtl/reaction_counter.sv
// Millisecond reaction counter: pseudo-random foreperiod, GO lamp, saturating
// tick count, false-start detection, driven by the game FSM's 3-bit flag.
module reaction_counter #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned MAX_COUNT  = 999,
    parameter int unsigned DELAY_MIN  = 1000,
    parameter int unsigned DELAY_BITS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] flag,
    output logic [9:0] counter,
    output logic       go_led,
    output logic       early,
    output logic       tick
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam int unsigned DW  = DELAY_BITS + 11;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_RUN   = 3'd2,
        S_HOLD  = 3'd3,
        S_FALSE = 3'd4
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic            r_tick;
    logic [15:0]     r_lfsr;
    logic [DW-1:0]   r_delay;
    logic [9:0]      r_counter;
    logic            r_go;
    logic            r_early;

    logic            w_flag_clr;
    logic            w_flag_start;
    logic            w_flag_stop;
    logic            w_flag_halt;
    logic            w_expire;
    logic            w_wait_entry;
    logic            w_run_entry;
    logic            w_presc_clr;
    logic [PW-1:0]   w_presc_nxt;
    logic            w_lfsr_fb;
    logic [DW-1:0]   w_delay_load;
    logic [9:0]      w_count_inc;

    assign w_flag_clr   = (flag == 3'd0);
    assign w_flag_start = (flag == 3'd1);
    assign w_flag_stop  = (flag == 3'd2) || (flag == 3'd3);
    assign w_flag_halt  = flag[2] | flag[1];
    assign w_expire     = r_tick && (r_delay == DW'(1));
    assign w_wait_entry = (r_state == S_IDLE) && w_flag_start;
    assign w_run_entry  = (r_state == S_WAIT) && w_flag_start && w_expire;
    assign w_presc_clr  = w_wait_entry || w_run_entry;
    assign w_lfsr_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_delay_load = DW'(DELAY_MIN) + DW'(r_lfsr[DELAY_BITS-1:0]);
    assign w_count_inc  = (r_counter == 10'(MAX_COUNT)) ? r_counter : r_counter + 10'd1;

    // Prescaler restarts on WAIT/RUN entry so phase timing is exact from those edges
    always_comb begin
        w_presc_nxt = r_presc + PW'(1);
        if (w_presc_clr || (r_presc == PW'(DIV - 1))) begin
            w_presc_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_tick  <= (w_presc_nxt == PW'(DIV - 1));
        end
    end

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    // Game FSM: clear beats stop/query, which beats the tick action
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_delay   <= '0;
            r_counter <= '0;
            r_go      <= 1'b0;
            r_early   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_counter <= '0;
                    r_go      <= 1'b0;
                    r_early   <= 1'b0;
                    if (w_flag_start) begin
                        r_state <= S_WAIT;
                        r_delay <= w_delay_load;
                    end
                end
                S_WAIT: begin
                    if (w_flag_clr) begin
                        r_state   <= S_IDLE;
                        r_counter <= '0;
                        r_early   <= 1'b0;
                    end else if (w_flag_stop) begin
                        r_state   <= S_FALSE;
                        r_counter <= 10'(MAX_COUNT);
                        r_early   <= 1'b1;
                    end else if (w_flag_halt) begin
                        r_state <= S_HOLD;
                    end else if (w_expire) begin
                        r_state <= S_RUN;
                        r_go    <= 1'b1;
                    end else if (r_tick) begin
                        r_delay <= r_delay - DW'(1);
                    end
                end
                S_RUN: begin
                    if (w_flag_clr) begin
                        r_state   <= S_IDLE;
                        r_counter <= '0;
                        r_go      <= 1'b0;
                    end else if (w_flag_halt) begin
                        r_state <= S_HOLD;
                        r_go    <= 1'b0;
                    end else if (r_tick) begin
                        r_counter <= w_count_inc;
                    end
                end
                S_HOLD, S_FALSE: begin
                    if (w_flag_clr) begin
                        r_state   <= S_IDLE;
                        r_counter <= '0;
                        r_go      <= 1'b0;
                        r_early   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_counter <= '0;
                    r_go      <= 1'b0;
                    r_early   <= 1'b0;
                end
            endcase
        end
    end

    assign counter = r_counter;
    assign go_led  = r_go;
    assign early   = r_early;
    assign tick    = r_tick;

endmodule

// File: tb/tb_reaction_counter.sv
// Bench for reaction_counter: directed scenarios plus random flag sequences,
// checked every cycle against a timestamp-based reference model.
module tb_reaction_counter;

    localparam int CLK_HZ     = 1000;
    localparam int TICK_HZ    = 100;
    localparam int DIV        = CLK_HZ / TICK_HZ;
    localparam int MAX_COUNT  = 20;
    localparam int DELAY_MIN  = 4;
    localparam int DELAY_BITS = 2;

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_RUN   = 2;
    localparam int P_HOLD  = 3;
    localparam int P_FALSE = 4;

    logic       clk;
    logic       rst;
    logic [2:0] flag;
    logic [9:0] counter;
    logic       go_led;
    logic       early;
    logic       tick;

    int n_checks;
    int n_errors;

    // Reference model: phase plus edge timestamps, counts derived arithmetically
    int          m_n;
    int          m_base;
    int          m_phase;
    int          m_twait;
    int          m_fore;
    int          m_tgo;
    int          m_cnt;
    int          m_early;
    logic [15:0] m_lfsr;

    reaction_counter #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .MAX_COUNT (MAX_COUNT),
        .DELAY_MIN (DELAY_MIN),
        .DELAY_BITS(DELAY_BITS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flag   (flag),
        .counter(counter),
        .go_led (go_led),
        .early  (early),
        .tick   (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, m_n);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic b;
        b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {b, l[15:1]};
    endfunction

    task automatic model_reset();
        m_n     = 0;
        m_base  = 0;
        m_phase = P_IDLE;
        m_cnt   = 0;
        m_early = 0;
        m_lfsr  = 16'hACE1;
    endtask

    task automatic model_edge(input int f);
        int r;
        m_n++;
        r = int'(m_lfsr) % (1 << DELAY_BITS);
        m_lfsr = lfsr_step(m_lfsr);
        case (m_phase)
            P_IDLE: begin
                if (f == 1) begin
                    m_phase = P_WAIT;
                    m_twait = m_n;
                    m_fore  = DELAY_MIN + r;
                    m_base  = m_n;
                end
            end
            P_WAIT: begin
                if (f == 0) m_phase = P_IDLE;
                else if (f == 2 || f == 3) m_phase = P_FALSE;
                else if (f >= 4) m_phase = P_HOLD;
                else if (m_n == m_twait + m_fore * DIV) begin
                    m_phase = P_RUN;
                    m_tgo   = m_n;
                    m_base  = m_n;
                end
            end
            P_RUN: begin
                if (f == 0) m_phase = P_IDLE;
                else if (f >= 2) m_phase = P_HOLD;
                else begin
                    m_cnt = (m_n - m_tgo) / DIV;
                    if (m_cnt > MAX_COUNT) m_cnt = MAX_COUNT;
                end
            end
            default: begin
                if (f == 0) m_phase = P_IDLE;
            end
        endcase
        case (m_phase)
            P_IDLE, P_WAIT: begin m_cnt = 0;         m_early = 0; end
            P_FALSE:        begin m_cnt = MAX_COUNT; m_early = 1; end
            default: ;
        endcase
    endtask

    function automatic int model_tick();
        return (((m_n - m_base) % DIV) == DIV - 1) ? 1 : 0;
    endfunction

    task automatic check_outputs();
        check_eq("counter", int'(counter), m_cnt);
        check_eq("go_led", int'(go_led), (m_phase == P_RUN) ? 1 : 0);
        check_eq("early", int'(early), m_early);
        check_eq("tick", int'(tick), model_tick());
    endtask

    // Drive one flag value for one edge, then compare on the falling edge
    task automatic step(input logic [2:0] f);
        flag = f;
        @(posedge clk);
        model_edge(int'(f));
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_go(input string tag);
        int k;
        k = 0;
        while (m_phase != P_RUN && k < 300) begin
            step(3'd1);
            k++;
        end
        check_eq(tag, (m_phase == P_RUN) ? 1 : 0, 1);
    endtask

    task automatic wait_cnt(input string tag, input int target, input int need_tick);
        int k;
        k = 0;
        while (!(m_cnt == target && (need_tick == 0 || model_tick() == 1)) && k < 1000) begin
            step(3'd1);
            k++;
        end
        check_eq(tag, m_cnt, target);
    endtask

    initial begin
        logic [15:0] seed;
        int          exp_go;
        logic [2:0]  f;
        int          len;
        int          sel;

        n_checks = 0;
        n_errors = 0;
        model_reset();
        seed   = 16'hACE1;
        exp_go = 1 + (DELAY_MIN + int'(seed[DELAY_BITS-1:0])) * DIV;

        rst  = 1'b1;
        flag = 3'd0;
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // First game: foreperiod from the seed, first tick count
        wait_go("go_timeout");
        check_eq("go_edge", m_n, exp_go);
        repeat (DIV) step(3'd1);
        check_eq("count_after_div", int'(counter), 1);

        // Normal stop at 7, held through query modes, then cleared
        wait_cnt("reach7", 7, 0);
        step(3'd2);
        check_eq("stop_hold7", int'(counter), 7);
        check_eq("stop_go_off", int'(go_led), 0);
        for (int q = 4; q < 8; q++) repeat (7) step(3'(q));
        check_eq("query_hold7", int'(counter), 7);
        step(3'd0);
        check_eq("clear_cnt", int'(counter), 0);

        // Stop lands on a tick cycle: increment must be suppressed
        step(3'd1);
        wait_go("go_timeout2");
        wait_cnt("reach5_tick", 5, 1);
        check_eq("tick_before_stop", int'(tick), 1);
        step(3'd3);
        check_eq("stop_on_tick", int'(counter), 5);
        repeat (25) step(3'd3);
        step(3'd0);

        // False start
        repeat (5) step(3'd1);
        step(3'd2);
        check_eq("false_early", int'(early), 1);
        check_eq("false_cnt", int'(counter), MAX_COUNT);
        repeat (80) step(3'($urandom_range(1, 7)));
        check_eq("false_no_go", int'(go_led), 0);
        step(3'd0);
        check_eq("false_clr_early", int'(early), 0);
        check_eq("false_clr_cnt", int'(counter), 0);

        // Saturation beyond MAX_COUNT ticks
        step(3'd1);
        wait_go("go_timeout3");
        repeat ((MAX_COUNT + 10) * DIV) step(3'd1);
        check_eq("saturate", int'(counter), MAX_COUNT);
        step(3'd2);
        step(3'd0);

        // Asynchronous reset mid-run, then the foreperiod repeats
        step(3'd1);
        wait_go("go_timeout4");
        wait_cnt("reach9", 9, 0);
        #2 rst = 1'b1;
        #1;
        check_eq("areset_cnt", int'(counter), 0);
        check_eq("areset_go", int'(go_led), 0);
        check_eq("areset_early", int'(early), 0);
        check_eq("areset_tick", int'(tick), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_go("go_timeout5");
        check_eq("go_edge_repeat", m_n, exp_go);

        // Random flag sequences against the model
        for (int seg = 0; seg < 40; seg++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5)       f = 3'd1;
            else if (sel == 5) f = 3'd0;
            else               f = 3'($urandom_range(2, 7));
            len = int'($urandom_range(1, (f == 3'd1) ? 150 : 15));
            repeat (len) step(f);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reaction_counter.md
# reaction_counter

Millisecond reaction counter that feeds the 10-bit `counter` input of the game state machine and consumes its 3-bit `flag` output. On a start (`flag`=1) it waits a pseudo-random foreperiod, lights the GO lamp, then counts milliseconds until a stop, clear or query flag arrives. It flags false starts and saturates at a displayable maximum, so the stored scores (`counter`+1) stay within range.

## Interface
- CLK_HZ, 50_000_000: system clock frequency.
- TICK_HZ, 1000: count rate. The tick divisor is DIV = CLK_HZ/TICK_HZ, which must be ≥ 2.
- MAX_COUNT, 999: saturation value of `counter`. Must be ≤ 1022.
- DELAY_MIN, 1000: minimum foreperiod in ticks. Must be ≥ 1.
- DELAY_BITS, 11: width of the random foreperiod extension. The foreperiod is DELAY_MIN + lfsr[DELAY_BITS-1:0] ticks.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flag  input  3  mode from the state machine: 0 clear, 1 count, 2/3 stop by player 1/2, 4–7 query modes.
- counter  output  10  elapsed ticks since GO, registered.
- go_led  output  1  GO lamp, registered. High only in RUN.
- early  output  1  false-start indicator, registered.
- tick  output  1  one-cycle tick strobe from the prescaler, for debug and display refresh.

## Operation
- Prescaler: counts 0..DIV-1 and asserts `tick` for the one cycle where it equals DIV-1, then wraps to 0. It is cleared to 0 on entry to WAIT and on entry to RUN.
- LFSR: 16-bit Fibonacci LFSR, seed 16'hACE1, taps 16,14,13,11. It shifts every clock, including outside a game, and never reaches all-zero.
- Delay counter: a DELAY_BITS+11-bit down-counter. It is loaded with DELAY_MIN + lfsr[DELAY_BITS-1:0] on the IDLE→WAIT edge and decrements on each tick while in WAIT.
- States:
  - IDLE: counter=0, go_led=0, early=0. Moves to WAIT when flag==1.
  - WAIT:
    - counter=0, go_led=0.
    - On a tick with delay==1, moves to RUN.
    - flag 2/3 → FALSE.
    - flag 4–7 → HOLD, with counter left at 0.
    - flag 0 → IDLE.
  - RUN:
    - go_led=1.
    - On each tick with flag==1, counter increments, saturating at MAX_COUNT.
    - flag 2–7 → HOLD.
    - flag 0 → IDLE.
  - HOLD: counter frozen, go_led=0, early unchanged. flag 0 → IDLE. flag 1–7 → stay in HOLD.
  - FALSE: counter=MAX_COUNT, early=1, go_led=0. flag 0 → IDLE. Any other flag → stay in FALSE.
- Priority each cycle is: flag 0 clear, then stop/query flag, then tick action.
  - A stop flag on a tick cycle suppresses that increment.
  - In WAIT, a stop flag beats expiry: FALSE wins over RUN.
- Saturation: once counter==MAX_COUNT in RUN, further ticks hold the value. The state machine's +1 score capture therefore stays ≤ MAX_COUNT+1 ≤ 1023, with no 10-bit wrap.
- Reset mid-operation: all state clears immediately, asynchronously. The LFSR returns to its seed.

## Timing
- Reset values: counter=0, go_led=0, early=0, tick=0, state IDLE, prescaler=0, LFSR=16'hACE1.
- Flag changes take effect at the next rising edge; all outputs are registered, so there is one cycle of latency.
- GO timing:
  - go_led rises at the edge where WAIT→RUN.
  - counter reads 1 exactly DIV cycles after that edge, and N after N·DIV cycles.
- Stop capture:
  - `counter` does not change at the edge where flag first becomes 2/3. The state machine's stop edge therefore samples a stable value.
  - counter holds its value for as long as flag ≠ 0.
- Foreperiod: (DELAY_MIN + r)·DIV cycles from the WAIT entry edge to the RUN entry edge, where r is the LFSR slice latched at WAIT entry.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10), DELAY_MIN=4, DELAY_BITS=2, MAX_COUNT=20.
- Reset, then flag=1 at cycle 0 → go_led rises at edge 1 + (4+r)·10, where r = the LFSR slice the bench predicts from the seed. counter=0 until then, and counter=1 ten cycles after go_led rises.
- Normal stop: flag=2 after counter reaches 7 → counter stays 7, go_led falls next edge, and the value is held across flag 4–7. flag=0 → counter=0 next edge.
- Stop on a tick cycle: flag=3 asserted in the same cycle as tick while counter=5 → counter stays 5, not 6.
- False start: flag=2 during WAIT → early=1, counter=20, go_led never rises. flag=0 → early=0, counter=0.
- Saturation: no stop for more than 25 ticks in RUN → counter sticks at 20 and never wraps.
- Async reset in RUN at counter=9, asserted between clock edges → counter, go_led and early go to 0 immediately. The next flag=1 gives the same foreperiod as the first run.
